// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input combinational circuit through all 16 rows, double-samples its
// output per row and scores the measured truth table against an expected hex ID.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h0018
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic [15:0] table_out,
  output logic [15:0] unstable_mask,
  output logic [4:0]  mismatch_cnt,
  output logic        pass,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE1, SAMPLE2, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        s1_q, s1_d;
  logic [15:0] table_q, table_d;
  logic [15:0] unst_q, unst_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic        pass_q, pass_d;
  logic        busy_w;

  assign busy_w = (state_q == SETTLE) || (state_q == SAMPLE1) || (state_q == SAMPLE2);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    table_d = table_q;
    unst_d  = unst_q;
    mcnt_d  = mcnt_q;
    pass_d  = pass_q;
    if (abort && busy_w) begin
      // Partial results stay visible for debug; only the sequencing unwinds.
      state_d = IDLE;
      row_d   = 4'd0;
      cnt_d   = 8'd0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = SETTLE;
            row_d   = 4'd0;
            cnt_d   = 8'd0;
            table_d = 16'h0000;
            unst_d  = 16'h0000;
            mcnt_d  = 5'd0;
            pass_d  = 1'b0;
          end
        end
        SETTLE: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == SETTLE_LAST) state_d = SAMPLE1;
        end
        SAMPLE1: begin
          s1_d    = dut_out;
          state_d = SAMPLE2;
        end
        SAMPLE2: begin
          // Row r lands in table bit 15-r, i.e. the bitwise complement of r.
          table_d[~row_q] = dut_out;
          unst_d[~row_q]  = s1_q ^ dut_out;
          if (dut_out != EXPECTED[~row_q]) mcnt_d = mcnt_q + 5'd1;
          if (row_q == 4'd15) begin
            state_d = DONE;
            pass_d  = (mcnt_d == 5'd0) && (unst_d == 16'h0000);
          end else begin
            row_d   = row_q + 4'd1;
            cnt_d   = 8'd0;
            state_d = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 4'd0;
      cnt_q   <= 8'd0;
      s1_q    <= 1'b0;
      table_q <= 16'h0000;
      unst_q  <= 16'h0000;
      mcnt_q  <= 5'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      table_q <= table_d;
      unst_q  <= unst_d;
      mcnt_q  <= mcnt_d;
      pass_q  <= pass_d;
    end
  end

  assign {in1, in2, in3, in4} = row_q;
  assign table_out     = table_q;
  assign unstable_mask = unst_q;
  assign mismatch_cnt  = mcnt_q;
  assign pass          = pass_q;
  assign busy          = busy_w;
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweeper instances (default and fast/alternate-ID) driving a
// behavioural m0x0018 model with stuck-at and glitch fault injection.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, start2;
  logic [1:0] mode;
  logic glitch;
  logic dout1, dout2;

  logic a1, a2, a3, a4, b1, b2, b3, b4;
  logic [15:0] a_tab, a_unst, b_tab, b_unst;
  logic [4:0]  a_mc, b_mc;
  logic a_pass, a_busy, a_done, b_pass, b_busy, b_done;

  int checks = 0;
  int errors = 0;

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dout1),
    .in1(a1), .in2(a2), .in3(a3), .in4(a4),
    .table_out(a_tab), .unstable_mask(a_unst), .mismatch_cnt(a_mc),
    .pass(a_pass), .busy(a_busy), .done(a_done)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'h0019)) u_fast (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .dut_out(dout2),
    .in1(b1), .in2(b2), .in3(b3), .in4(b4),
    .table_out(b_tab), .unstable_mask(b_unst), .mismatch_cnt(b_mc),
    .pass(b_pass), .busy(b_busy), .done(b_done)
  );

  function automatic logic model(input logic [3:0] r);
    return r[3] & ((r[2] & ~r[1] & ~r[0]) | (~r[2] & r[1] & r[0]));
  endfunction

  always_comb begin
    dout1 = 1'b0;
    case (mode)
      2'd0: dout1 = model({a1, a2, a3, a4});
      2'd1: dout1 = 1'b0;
      default: dout1 = 1'b1;
    endcase
    dout1 = dout1 ^ glitch;
    dout2 = model({b1, b2, b3, b4});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in"},   {a1, a2, a3, a4}, 4'h0);
    chk({tag, "_tab"},  a_tab, 16'h0000);
    chk({tag, "_unst"}, a_unst, 16'h0000);
    chk({tag, "_mc"},   a_mc, 5'd0);
    chk({tag, "_flags"}, {a_pass, a_busy, a_done}, 3'b000);
  endtask

  // Start at edge k, then confirm done is low at k+95 and high at k+96.
  task automatic sweep(input string tag);
    pulse_start();
    tick(95);
    chk({tag, "_done95"}, {a_done, a_busy}, 2'b01);
    tick();
    chk({tag, "_done96"}, {a_done, a_busy}, 2'b10);
  endtask

  task automatic chk_result(input string tag, input logic [15:0] tab, input logic [15:0] unst,
                            input logic [4:0] mc, input logic ps);
    chk({tag, "_tab"},  a_tab, tab);
    chk({tag, "_unst"}, a_unst, unst);
    chk({tag, "_mc"},   a_mc, mc);
    chk({tag, "_pass"}, a_pass, ps);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    mode = 2'd0; glitch = 1'b0;
    tick(2);
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // 1: correct circuit
    sweep("t1");
    chk_result("t1", 16'h0018, 16'h0000, 5'd0, 1'b1);
    chk("t1_in", {a1, a2, a3, a4}, 4'hF);

    // 2: stuck-at faults
    mode = 2'd1;
    sweep("t2a");
    chk_result("t2a", 16'h0000, 16'h0000, 5'd2, 1'b0);
    mode = 2'd2;
    sweep("t2b");
    chk_result("t2b", 16'hFFFF, 16'h0000, 5'd14, 1'b0);

    // 3: glitch on the row-5 SAMPLE1 edge (k+35)
    mode = 2'd0;
    pulse_start();
    tick(34);
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    tick(60);
    chk("t3_done95", a_done, 1'b0);
    tick();
    chk("t3_done96", a_done, 1'b1);
    chk_result("t3", 16'h0018, 16'h0400, 5'd0, 1'b0);

    // 4: restart ignored mid-sweep; then abort during row 7 SETTLE
    pulse_start();
    tick(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(74);
    chk("t4_done95", a_done, 1'b0);
    tick();
    chk("t4_done96", a_done, 1'b1);
    chk("t4_pass", a_pass, 1'b1);
    mode = 2'd2;
    pulse_start();
    tick(43);
    chk("t4_row7", {a1, a2, a3, a4}, 4'h7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_ab_flags", {a_pass, a_busy, a_done}, 3'b000);
    chk("t4_ab_in", {a1, a2, a3, a4}, 4'h0);
    chk("t4_ab_tab", a_tab, 16'hFE00);
    chk("t4_ab_mc", a_mc, 5'd7);
    tick(3);
    chk("t4_idle", a_busy, 1'b0);
    mode = 2'd0;
    sweep("t4c");
    chk_result("t4c", 16'h0018, 16'h0000, 5'd0, 1'b1);

    // 5: reset on the row-10 SAMPLE1 edge (k+65), partial results non-zero
    mode = 2'd2;
    pulse_start();
    tick(64);
    chk("t5_pre_tab", a_tab, 16'hFFC0);
    rst = 1'b1;
    tick();
    chk_reset("t5");
    rst = 1'b0;
    tick();
    mode = 2'd0;
    sweep("t5b");
    chk_result("t5b", 16'h0018, 16'h0000, 5'd0, 1'b1);

    // 6: SETTLE_CYCLES=1, EXPECTED=0019; each row held exactly 3 cycles
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    begin
      int bad = 0;
      int badj = -1;
      for (int j = 0; j < 48; j++) begin
        if ({b1, b2, b3, b4} !== 4'(j / 3)) begin
          bad++;
          if (badj < 0) badj = j;
        end
        if (j == 47) chk("t6_done47", b_done, 1'b0);
        tick();
      end
      chk("t6_seq_bad_rows", bad, 0);
      if (bad != 0) $display("first bad cycle %0d", badj);
    end
    chk("t6_done48", {b_done, b_busy}, 2'b10);
    chk("t6_tab", b_tab, 16'h0018);
    chk("t6_mc", b_mc, 5'd1);
    chk("t6_pass", b_pass, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
